// File: rtl/overflow_counter_pkg.sv
// Shared constants for the event/cycle counter family.
package overflow_counter_pkg;

  // Default counter width when the instantiating datapath does not override it.
  localparam int COUNTER_WIDTH_DEFAULT = 4;

  // Widest counter the block is built for; the count path is a plain WIDTH-bit add.
  localparam int COUNTER_WIDTH_MAX = 32;

endpackage : overflow_counter_pkg

// File: rtl/overflow_counter.sv
// Free-running up-counter with synchronous enable and a sticky wrap flag.
// Counts enabled cycles modulo 2^WIDTH; the first wrap latches overflow_out
// until the next reset so a consumer can tell the count value has aliased.
module overflow_counter
  import overflow_counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] counter_out,
  output logic             overflow_out
);

  // Terminal count: the registered value at which the next enabled edge wraps.
  localparam logic [WIDTH-1:0] COUNT_ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             overflow_q;
  logic             overflow_d;
  logic             at_max;

  // Wrap detection looks at the registered count, never at the sum.
  assign at_max = (count_q == COUNT_ALL_ONES);

  // Next-state: hold by default; on enable increment (carry dropped) and set the
  // flag when wrapping. The flag is only ever raised here, never cleared.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (enable) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      if (at_max) begin
        overflow_d = 1'b1;
      end
    end
  end

  // State register: synchronous reset takes priority over counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs come straight from the registers: no input-to-output path.
  assign counter_out  = count_q;
  assign overflow_out = overflow_q;

endmodule : overflow_counter

// File: tb/tb_overflow_counter.sv
// Directed self-checking bench for overflow_counter at WIDTH=4.
module tb_overflow_counter;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [W-1:0] counter_out;
  logic         overflow_out;

  int checks;
  int failures;

  overflow_counter #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .counter_out (counter_out),
    .overflow_out(overflow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, report a mismatch, print one line per check.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s value=%0d", tag, got);
    end
  endtask

  // Drive inputs, take one rising edge, settle just past it before sampling.
  task automatic step(input logic en, input logic rst);
    enable = en;
    reset  = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input int cnt, input logic ovf);
    check({tag, ".cnt"}, 32'(counter_out), 32'(cnt));
    check({tag, ".ovf"}, 32'(overflow_out), 32'(ovf));
  endtask

  initial begin
    int exp_cnt;
    checks   = 0;
    failures = 0;
    enable   = 1'b0;
    reset    = 1'b0;
    @(negedge clk);

    // Reset with enable high: reset wins on both edges.
    step(1'b1, 1'b1);
    expect_state("reset_e1", 0, 1'b0);
    step(1'b1, 1'b1);
    expect_state("reset_e2", 0, 1'b0);

    // Basic count 1..5.
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0);
      expect_state($sformatf("count_%0d", i), i, 1'b0);
    end

    // Up to 7, hold three cycles, then resume to 8.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    expect_state("count_7", 7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      expect_state($sformatf("hold7_%0d", i), 7, 1'b0);
    end
    step(1'b1, 1'b0);
    expect_state("resume_8", 8, 1'b0);

    // Reset pulse between edges has no effect (synchronous reset).
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step(1'b0, 1'b0);
    expect_state("mid_cycle_reset", 8, 1'b0);

    // Wrap: 16 enabled edges from 0; 16th reads 0 with flag set.
    step(1'b0, 1'b1);
    expect_state("wrap_reset", 0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0);
      expect_state($sformatf("wrap_%0d", i), i % 16, (i == 16) ? 1'b1 : 1'b0);
    end

    // Sticky: 20 cycles with enable toggling; flag stays set, count continues.
    exp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      logic en;
      en = (i % 2 == 0);
      step(en, 1'b0);
      if (en) exp_cnt = (exp_cnt + 1) % 16;
      expect_state($sformatf("sticky_%0d", i), exp_cnt, 1'b1);
    end

    // Idle at max: sit at 15 with enable low, then one enabled edge wraps.
    step(1'b0, 1'b1);
    expect_state("idle_reset", 0, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
    expect_state("idle_at15", 15, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      expect_state($sformatf("idle15_%0d", i), 15, 1'b0);
    end
    step(1'b1, 1'b0);
    expect_state("idle_wrap", 0, 1'b1);

    // Reset on the wrap edge wins, then a fresh 16-edge run sets the flag again.
    step(1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
    expect_state("rstwrap_at15", 15, 1'b0);
    step(1'b1, 1'b1);
    expect_state("rstwrap_edge", 0, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
    expect_state("rerun_15", 15, 1'b0);
    step(1'b1, 1'b0);
    expect_state("rerun_wrap", 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_overflow_counter

// File: doc/overflow_counter.md
# overflow_counter

Free-running up-counter with a synchronous enable and a sticky overflow flag. It counts enabled clock cycles modulo 2^WIDTH and latches the first wrap-around until reset. It is used as a generic event or cycle counter inside larger datapaths. The overflow flag tells the consumer that the count value has aliased.

## Interface
- WIDTH, default 4: counter width in bits; legal range 1–32.
- clk  input  1  rising-edge clock; all state changes on posedge clk.
- reset  input  1  reset reset, synchronous, active-high; clock clk.
- enable  input  1  count enable; when high, the counter advances by 1 on the next clock edge.
- counter_out  output  WIDTH  current count, driven directly from a register.
- overflow_out  output  1  sticky wrap flag, driven directly from a register.

## Operation
- Reset (reset==1 at a posedge): counter_out <= 0 and overflow_out <= 0. Reset has priority over enable.
- Count (reset==0, enable==1): counter_out <= counter_out + 1, modulo 2^WIDTH. The carry-out is discarded.
- Hold (reset==0, enable==0): counter_out and overflow_out keep their values.
- Wrap: when enable==1 and counter_out == all-ones (2^WIDTH−1), the next counter_out is 0 and overflow_out <= 1 on the same edge.
- Sticky: after overflow_out is set, it stays 1 through further counting, holds and wraps. Only reset clears it.
- Idle at max: if counter_out == all-ones and enable==0, there is no wrap and overflow_out is unchanged.
- Reset during the wrap edge: reset wins, so both outputs go to 0.
- Arithmetic: use an unsigned WIDTH-bit add. The wrap detect uses the registered counter_out value, not the sum.
- Pre-reset state: the power-up state is undefined. The first reset edge defines both outputs.

## Timing
- Latency is 1 cycle. Outputs reflect inputs sampled at the previous posedge.
- The block has no combinational path from inputs to outputs.
- Reset is synchronous, so asserting it between edges has no effect until the next posedge.
- Throughput is one increment per clock while enable is high.
- A full wrap takes 2^WIDTH enabled cycles from 0. For WIDTH=4, the 16th enabled edge after reset sets overflow_out, and counter_out reads 0 in that same cycle.

## Structure
- Single module, overflow_counter, with no sub-modules.
- The all-ones terminal value is computed locally as {WIDTH{1'b1}}.
- A shared package is optional. If the team's counter_pkg exists, put a default-width constant COUNTER_WIDTH_DEFAULT = 4 there. The module needs no typedefs.
- Recommended body:
  - one always block on posedge clk;
  - a reset branch;
  - an enable branch containing the increment and the wrap/flag set.
- The overflow update belongs inside the enable branch. It must never write 0 outside reset.

## Test plan
- Reset: drive enable=1 and reset=1 for 2 cycles → counter_out=0 and overflow_out=0 after the first edge.
- Basic count: reset, then enable=1 for 5 cycles → counter_out steps 1,2,3,4,5 and overflow_out stays 0.
- Hold: at count 7, drive enable=0 for 3 cycles → counter_out stays 7. Re-enable → 8 on the next edge.
- Wrap and sticky (WIDTH=4): reset, then enable=1 for 16 cycles → counter_out goes 15→0 with overflow_out=1 on that edge. Continue 20 more cycles with enable toggling → overflow_out remains 1 and the count continues 1,2,…
- Idle at max: count to 15, drive enable=0 for 4 cycles → counter_out=15 and overflow_out=0. One enabled edge → counter_out=0 and overflow_out=1.
- Reset on the wrap edge: at count 15 with enable=1, assert reset → counter_out=0 and overflow_out=0. Then re-run 16 enabled cycles → overflow_out=1 again.
